// File: rtl/pq_dispatcher.sv
// Dispatcher between an event stream and a min-heap priority queue.
// Arbitrates enqueue/dequeue commands and buffers one dequeued event.
module pq_dispatcher #(
    parameter int DWIDTH         = 16,
    parameter int HDEPTH         = 5,
    parameter int MAX_ENQ_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ev_in_valid,
    output logic              ev_in_ready,
    input  logic [DWIDTH-1:0] ev_in_data,
    output logic              ev_out_valid,
    input  logic              ev_out_ready,
    output logic [DWIDTH-1:0] ev_out_data,
    output logic              pq_enq,
    output logic              pq_deq,
    output logic [DWIDTH-1:0] pq_inp_data,
    input  logic [DWIDTH-1:0] pq_out_data,
    input  logic              pq_full,
    input  logic              pq_empty,
    input  logic              pq_ready,
    input  logic [HDEPTH-1:0] pq_elem_cnt
);

    localparam int SW = $clog2(MAX_ENQ_STREAK + 1);

    typedef enum logic [1:0] {
        IDLE,
        ENQ_WAIT,
        DEQ_WAIT
    } state_e;

    state_e            state_q, state_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              out_v_q, out_v_d;
    logic [DWIDTH-1:0] out_q, out_d;

    logic idle, force_deq, deq_ok, enq_fire, deq_fire;
    logic unused_cnt;

    // Element count is informational; pq_full/pq_empty carry the limits.
    assign unused_cnt = ^pq_elem_cnt;

    always_comb begin
        idle        = (state_q == IDLE);
        force_deq   = (streak_q >= SW'(MAX_ENQ_STREAK));
        deq_ok      = idle && pq_ready && !pq_empty && !out_v_q;
        ev_in_ready = !rst && idle && pq_ready && !pq_full
                      && !(force_deq && deq_ok);
        enq_fire    = ev_in_valid && ev_in_ready;
        deq_fire    = !rst && deq_ok && !enq_fire;
    end

    assign pq_enq       = enq_fire;
    assign pq_deq       = deq_fire;
    assign pq_inp_data  = enq_fire ? ev_in_data : '0;
    assign ev_out_valid = out_v_q;
    assign ev_out_data  = out_q;

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        out_v_d  = out_v_q;
        out_d    = out_q;
        unique case (state_q)
            IDLE: begin
                if (enq_fire) begin
                    state_d = ENQ_WAIT;
                    if (!force_deq) streak_d = streak_q + SW'(1);
                end else if (deq_fire) begin
                    state_d  = DEQ_WAIT;
                    streak_d = '0;
                end
            end
            ENQ_WAIT: state_d = IDLE;
            DEQ_WAIT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        // A dequeue only fires with the buffer empty, so load wins over drain.
        if (deq_fire) begin
            out_v_d = 1'b1;
            out_d   = pq_out_data;
        end else if (out_v_q && ev_out_ready) begin
            out_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            streak_q <= '0;
            out_v_q  <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            out_v_q  <= out_v_d;
            out_q    <= out_d;
        end
    end

endmodule

// File: doc/pq_dispatcher.md
PQ_DISPATCHER -- requirements
Module: pq_dispatcher

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, event key/data width (matches heap data bus).
REQ-002 SHALL have parameter HDEPTH, default 5, heap element-count width; heap capacity 2^HDEPTH-1.
REQ-003 SHALL have parameter MAX_ENQ_STREAK, default 4, consecutive enqueues before a dequeue is forced.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 ev_in_valid  input  1  upstream event offered for enqueue.
REQ-007 ev_in_ready  output  1  event accepted this cycle when high with ev_in_valid.
REQ-008 ev_in_data  input  DWIDTH  event key, smaller = higher priority.
REQ-009 ev_out_valid  output  1  minimum event held in output register.
REQ-010 ev_out_ready  input  1  downstream consumes ev_out_data this cycle.
REQ-011 ev_out_data  output  DWIDTH  dequeued event key.
REQ-012 pq_enq  output  1  one-cycle enqueue command to heap.
REQ-013 pq_deq  output  1  one-cycle dequeue command to heap.
REQ-014 pq_inp_data  output  DWIDTH  enqueue data, valid when pq_enq high.
REQ-015 pq_out_data  input  DWIDTH  heap root (current minimum), valid combinationally while pq_deq high.
REQ-016 pq_full, pq_empty, pq_ready  input  1 each  heap status.
REQ-017 pq_elem_cnt  input  HDEPTH  heap element count.

Function
REQ-018 SHALL implement FSM states IDLE, ENQ_WAIT, DEQ_WAIT; commands issued only from IDLE.
REQ-019 SHALL never assert pq_enq and pq_deq in the same cycle; each asserted at most one cycle per command.
REQ-020 SHALL issue a command only when pq_ready=1; after any command, exactly one WAIT cycle, then IDLE.
REQ-021 force_deq SHALL be enq_streak >= MAX_ENQ_STREAK.
REQ-022 deq_ok SHALL be IDLE && pq_ready && !pq_empty && !ev_out_valid.
REQ-023 ev_in_ready SHALL be combinational: IDLE && pq_ready && !pq_full && !(force_deq && deq_ok).
REQ-024 on ev_in_valid && ev_in_ready: pq_enq=1, pq_inp_data=ev_in_data same cycle; next state ENQ_WAIT; enq_streak increments, saturating at MAX_ENQ_STREAK.
REQ-025 dequeue SHALL fire when deq_ok && (!ev_in_valid || !ev_in_ready); pq_deq=1; pq_out_data registered into ev_out_data at that edge; ev_out_valid=1 next cycle; next state DEQ_WAIT; enq_streak cleared.
REQ-026 enqueue SHALL take priority over dequeue unless force_deq, pq_full, or enqueue not possible.
REQ-027 ev_out_valid SHALL clear on the edge where ev_out_ready=1; ev_out_data SHALL hold stable while ev_out_valid && !ev_out_ready.
REQ-028 no new dequeue while ev_out_valid=1 (single-entry output buffer, no overwrite).
REQ-029 pq_full=1: ev_in_ready=0; dequeue still permitted.
REQ-030 pq_empty=1: no dequeue; enq_streak unaffected.
REQ-031 pq_ready=0 in IDLE: no command, state holds, ev_in_ready=0.
REQ-032 pq_inp_data SHALL be zero when pq_enq=0.

Reset
REQ-033 rst=1 at a rising edge: state=IDLE, enq_streak=0, ev_out_valid=0, ev_out_data=0, pq_enq=0, pq_deq=0, pq_inp_data=0.
REQ-034 rst mid-command (ENQ_WAIT/DEQ_WAIT or ev_out_valid=1) SHALL discard buffered event and return to IDLE; no command issued in the reset cycle.

Verification
REQ-035 Enqueue 30, 10, 20 (ev_out_ready=0 throughout) -> three pq_enq pulses, each followed by one idle cycle; next dequeue yields ev_out_data=10.
REQ-036 Heap holds 10, 20, 30; ev_in_valid=0, ev_out_ready=1 -> ev_out_data sequence 10, 20, 30; pq_deq pulses separated by exactly one cycle; pq_empty blocks a fourth pq_deq.
REQ-037 ev_in_valid held with keys 50..55, heap contains 5, output empty -> four pq_enq, then forced pq_deq delivering 5, then enqueues resume.
REQ-038 pq_full=1 (pq_elem_cnt=31), ev_in_valid=1 -> ev_in_ready=0, pq_enq never asserted; dequeue of minimum still occurs.
REQ-039 ev_out_valid=1 with ev_out_ready=0 for 10 cycles -> ev_out_data stable, no pq_deq; ev_out_ready=1 -> valid clears next edge.
REQ-040 rst asserted in DEQ_WAIT with ev_out_valid=1 -> next cycle all outputs zero, state IDLE.
